// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// plus a per-register pending-write scoreboard used for RAW stalls.
module regfile_wb_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           req,
   input  logic [ADDR_W-1:0]    req_addr_0,
   input  logic [ADDR_W-1:0]    req_addr_1,
   input  logic [ADDR_W-1:0]    req_addr_2,
   input  logic [DATA_W-1:0]    req_data_0,
   input  logic [DATA_W-1:0]    req_data_1,
   input  logic [DATA_W-1:0]    req_data_2,
   output logic [2:0]           gnt,
   output logic [ADDR_W-1:0]    write_addr,
   output logic [DATA_W-1:0]    write_data,
   output logic                 RegWrite,
   input  logic                 rsv_valid,
   input  logic [ADDR_W-1:0]    rsv_addr,
   output logic [2**ADDR_W-1:0] busy
);

   localparam int NREG = 2**ADDR_W;

   logic [1:0]        ptr_r;
   logic [1:0]        ptr_nxt_s;
   logic [2:0]        rr_gnt_s;
   logic [2:0]        gnt_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_data_s;
   logic [ADDR_W-1:0] write_addr_r;
   logic [DATA_W-1:0] write_data_r;
   logic              reg_write_r;
   logic [NREG-1:0]   busy_r;
   logic [NREG-1:0]   busy_nxt_s;

   // Round-robin pick starting at ptr; an illegal pointer behaves like ptr=0
   always_comb begin
      rr_gnt_s = 3'b000;
      case (ptr_r)
         2'd1: begin
            if (req[1])      rr_gnt_s = 3'b010;
            else if (req[2]) rr_gnt_s = 3'b100;
            else if (req[0]) rr_gnt_s = 3'b001;
            else             rr_gnt_s = 3'b000;
         end
         2'd2: begin
            if (req[2])      rr_gnt_s = 3'b100;
            else if (req[0]) rr_gnt_s = 3'b001;
            else if (req[1]) rr_gnt_s = 3'b010;
            else             rr_gnt_s = 3'b000;
         end
         default: begin
            if (req[0])      rr_gnt_s = 3'b001;
            else if (req[1]) rr_gnt_s = 3'b010;
            else if (req[2]) rr_gnt_s = 3'b100;
            else             rr_gnt_s = 3'b000;
         end
      endcase
      gnt_s = rst ? 3'b000 : rr_gnt_s;
   end

   // Select the granted source's payload and the pointer that follows it
   always_comb begin
      sel_addr_s = {ADDR_W{1'b0}};
      sel_data_s = {DATA_W{1'b0}};
      ptr_nxt_s  = ptr_r;
      case (gnt_s)
         3'b001: begin
            sel_addr_s = req_addr_0;
            sel_data_s = req_data_0;
            ptr_nxt_s  = 2'd1;
         end
         3'b010: begin
            sel_addr_s = req_addr_1;
            sel_data_s = req_data_1;
            ptr_nxt_s  = 2'd2;
         end
         3'b100: begin
            sel_addr_s = req_addr_2;
            sel_data_s = req_data_2;
            ptr_nxt_s  = 2'd0;
         end
         default: begin
            sel_addr_s = {ADDR_W{1'b0}};
            sel_data_s = {DATA_W{1'b0}};
            ptr_nxt_s  = ptr_r;
         end
      endcase
   end

   // Scoreboard next state: a new reservation beats a same-edge clear; r0 never busy
   always_comb begin
      busy_nxt_s = busy_r;
      for (int k = 0; k < NREG; k++) begin
         if (k == 0)
            busy_nxt_s[k] = 1'b0;
         else if (rsv_valid && (rsv_addr == ADDR_W'(k)))
            busy_nxt_s[k] = 1'b1;
         else if (reg_write_r && (write_addr_r == ADDR_W'(k)))
            busy_nxt_s[k] = 1'b0;
         else
            busy_nxt_s[k] = busy_r[k];
      end
   end

   // Arbitration pointer
   always_ff @(posedge clk) begin
      if (rst) ptr_r <= 2'd0;
      else     ptr_r <= ptr_nxt_s;
   end

   // Registered write port; a transfer to r0 is accepted but never strobes RegWrite
   always_ff @(posedge clk) begin
      if (rst) begin
         write_addr_r <= {ADDR_W{1'b0}};
         write_data_r <= {DATA_W{1'b0}};
         reg_write_r  <= 1'b0;
      end else if (gnt_s != 3'b000) begin
         write_addr_r <= sel_addr_s;
         write_data_r <= sel_data_s;
         reg_write_r  <= (sel_addr_s != {ADDR_W{1'b0}});
      end else begin
         reg_write_r  <= 1'b0;
      end
   end

   // Pending-write mask
   always_ff @(posedge clk) begin
      if (rst) busy_r <= {NREG{1'b0}};
      else     busy_r <= busy_nxt_s;
   end

   assign gnt        = gnt_s;
   assign write_addr = write_addr_r;
   assign write_data = write_data_r;
   assign RegWrite   = reg_write_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a sequential vector table plus
// hand-written reset and reset-mid-flight sequences, with a register file model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [4:0]  req_addr_0, req_addr_1, req_addr_2;
   logic [15:0] req_data_0, req_data_1, req_data_2;
   logic [2:0]  gnt;
   logic [4:0]  write_addr;
   logic [15:0] write_data;
   logic        reg_write;
   logic        rsv_valid;
   logic [4:0]  rsv_addr;
   logic [31:0] busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] rf [32] = '{default: 16'h0000};

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_addr_2(req_addr_2),
      .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2),
      .gnt(gnt), .write_addr(write_addr), .write_data(write_data),
      .RegWrite(reg_write), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy)
   );

   // Register file model: commits on RegWrite, r0 hardwired, write dropped under reset
   always @(posedge clk) begin
      if (!rst && reg_write && write_addr != 5'd0)
         rf[write_addr] <= write_data;
   end

   typedef struct {
      logic [2:0]  req;
      logic [4:0]  a0, a1, a2;
      logic [15:0] d0, d1, d2;
      logic        rv;
      logic [4:0]  ra;
      logic [2:0]  egnt;
      logic        erw;
      logic [4:0]  ewa;
      logic [15:0] ewd;
      logic [31:0] ebusy;
      logic        chk_wp;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] r, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic rv, input logic [4:0] ra);
      req = r;
      req_addr_0 = a0; req_addr_1 = a1; req_addr_2 = a2;
      req_data_0 = d0; req_data_1 = d1; req_data_2 = d2;
      rsv_valid = rv; rsv_addr = ra;
   endtask

   initial begin
      // round robin, all three requesting: 0,1,2,0,1,2
      vecs[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5'd0, 3'b001, 1'b1, 5'd1, 16'h1111, 32'h0, 1'b1};
      vecs[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5'd0, 3'b010, 1'b1, 5'd2, 16'h2222, 32'h0, 1'b1};
      vecs[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5'd0, 3'b100, 1'b1, 5'd3, 16'h3333, 32'h0, 1'b1};
      vecs[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5'd0, 3'b001, 1'b1, 5'd1, 16'h1111, 32'h0, 1'b1};
      vecs[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5'd0, 3'b010, 1'b1, 5'd2, 16'h2222, 32'h0, 1'b1};
      vecs[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5'd0, 3'b100, 1'b1, 5'd3, 16'h3333, 32'h0, 1'b1};
      // single source 1, ptr back at 0
      vecs[6]  = '{3'b010, 5'd0, 5'd4, 5'd0, 16'h0000, 16'h0006, 16'h0000, 1'b0, 5'd0, 3'b010, 1'b1, 5'd4, 16'h0006, 32'h0, 1'b1};
      vecs[7]  = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd4, 16'h0006, 32'h0, 1'b1};
      // reserve 8, source 2 writes 8, busy clears on the following edge
      vecs[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 5'd8, 3'b000, 1'b0, 5'd4, 16'h0006, 32'h0000_0100, 1'b1};
      vecs[9]  = '{3'b100, 5'd0, 5'd0, 5'd8, 16'h0000, 16'h0000, 16'h000E, 1'b0, 5'd0, 3'b100, 1'b1, 5'd8, 16'h000E, 32'h0000_0100, 1'b1};
      vecs[10] = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd8, 16'h000E, 32'h0000_0000, 1'b1};
      // re-reserve 8 on the clearing edge: set wins
      vecs[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 5'd8, 3'b000, 1'b0, 5'd8, 16'h000E, 32'h0000_0100, 1'b1};
      vecs[12] = '{3'b001, 5'd8, 5'd0, 5'd0, 16'h00AA, 16'h0000, 16'h0000, 1'b0, 5'd0, 3'b001, 1'b1, 5'd8, 16'h00AA, 32'h0000_0100, 1'b1};
      vecs[13] = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 5'd8, 3'b000, 1'b0, 5'd8, 16'h00AA, 32'h0000_0100, 1'b1};
      // set and clear on different addresses in the same edge
      vecs[14] = '{3'b010, 5'd0, 5'd8, 5'd0, 16'h0000, 16'h0077, 16'h0000, 1'b1, 5'd5, 3'b010, 1'b1, 5'd8, 16'h0077, 32'h0000_0120, 1'b1};
      vecs[15] = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 5'd9, 3'b000, 1'b0, 5'd8, 16'h0077, 32'h0000_0220, 1'b1};
      // r0: granted but no RegWrite, reservation ignored
      vecs[16] = '{3'b001, 5'd0, 5'd0, 5'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 5'd0, 3'b001, 1'b0, 5'd0, 16'h0000, 32'h0000_0220, 1'b0};
      vecs[17] = '{3'b000, 5'd0, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 16'h0000, 32'h0000_0220, 1'b0};

      // reset with every input active
      rst = 1'b1;
      drive(3'b111, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 16'h3333, 1'b1, 5'd3);
      #1;
      chk("rst_gnt_pre", {29'd0, gnt}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_gnt", {29'd0, gnt}, 32'd0);
         chk("rst_regwrite", {31'd0, reg_write}, 32'd0);
         chk("rst_busy", busy, 32'd0);
         chk("rst_waddr", {27'd0, write_addr}, 32'd0);
         chk("rst_wdata", {16'd0, write_data}, 32'd0);
      end
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2,
               vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].rv, vecs[i].ra);
         #1;
         chk($sformatf("v%0d_gnt", i), {29'd0, gnt}, {29'd0, vecs[i].egnt});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_regwrite", i), {31'd0, reg_write}, {31'd0, vecs[i].erw});
         chk($sformatf("v%0d_busy", i), busy, vecs[i].ebusy);
         if (vecs[i].chk_wp) begin
            chk($sformatf("v%0d_waddr", i), {27'd0, write_addr}, {27'd0, vecs[i].ewa});
            chk($sformatf("v%0d_wdata", i), {16'd0, write_data}, {16'd0, vecs[i].ewd});
         end else begin
            chk($sformatf("v%0d_busy0", i), {31'd0, busy[0]}, 32'd0);
         end
      end

      chk("rf1", {16'd0, rf[1]}, 32'h1111);
      chk("rf3", {16'd0, rf[3]}, 32'h3333);
      chk("rf4", {16'd0, rf[4]}, 32'h0006);
      chk("rf8", {16'd0, rf[8]}, 32'h0077);

      // reset mid-flight: grant source 0 at edge N, rst sampled at N+1
      drive(3'b001, 5'd20, 5'd0, 5'd0, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 5'd0);
      #1;
      chk("mid_gnt0", {29'd0, gnt}, 32'b001);
      step();
      chk("mid_regwrite_n", {31'd0, reg_write}, 32'd1);
      chk("mid_waddr_n", {27'd0, write_addr}, 32'd20);
      rst = 1'b1;
      drive(3'b110, 5'd0, 5'd21, 5'd22, 16'h0000, 16'hCAFE, 16'h0D0D, 1'b1, 5'd7);
      #1;
      chk("mid_gnt_rst", {29'd0, gnt}, 32'd0);
      step();
      chk("mid_regwrite_drop", {31'd0, reg_write}, 32'd0);
      chk("mid_busy_rst", busy, 32'd0);
      chk("mid_rf20", {16'd0, rf[20]}, 32'd0);
      rst = 1'b0;
      rsv_valid = 1'b0;
      #1;
      chk("mid_gnt_after", {29'd0, gnt}, 32'b010);
      step();
      chk("mid_regwrite_after", {31'd0, reg_write}, 32'd1);
      chk("mid_waddr_after", {27'd0, write_addr}, 32'd21);
      chk("mid_wdata_after", {16'd0, write_data}, 32'hCAFE);
      chk("mid_rf20_final", {16'd0, rf[20]}, 32'd0);
      req = 3'b100;
      #1;
      chk("mid_gnt_next", {29'd0, gnt}, 32'b100);
      step();
      req = 3'b000;
      step();
      chk("mid_rf21", {16'd0, rf[21]}, 32'hCAFE);
      chk("mid_rf22", {16'd0, rf[22]}, 32'h0D0D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and reservation scoreboard for the 16-bit, 32-entry register file. Three write-back sources share the register file's single write port: 0 = ALU, 1 = data memory load, 2 = multiplier. The block round-robin arbitrates their requests and drives the write port with registered outputs. It also tracks per-register pending writes (busy mask) so issue logic can stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 16, write-data width (matches register file word)
- ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
- clk  input  1  rising-edge clock shared with the register file
- rst  input  1  synchronous, active-high reset
- req  input  3  per-source write-back request
- req_addr_0/1/2  input  ADDR_W  destination register of source 0/1/2
- req_data_0/1/2  input  DATA_W  result data of source 0/1/2
- gnt  output  3  one-hot grant, combinational from req and pointer
- write_addr  output  ADDR_W  to register file write_addr, registered
- write_data  output  DATA_W  to register file write_data, registered
- RegWrite  output  1  to register file RegWrite, registered
- rsv_valid  input  1  issue logic reserves a destination this cycle
- rsv_addr  input  ADDR_W  register being reserved
- busy  output  2**ADDR_W  bit k = write to register k pending, registered

## Operation
- **Handshake:**
  - A source raises req[i] with addr/data and holds all three stable until it samples gnt[i]=1 at a rising edge.
  - Transfer happens on that edge. The source may drop req or present a new request the next cycle.
  - gnt[i] is never 1 when req[i]=0. At most one gnt bit is set per cycle.
- **Arbitration:** round-robin pointer ptr in 0..2.
  - Priority order is ptr, ptr+1, ptr+2 (mod 3). Grant goes to the first requesting source in that order.
  - After a transfer from source i, ptr <= (i+1) mod 3. With no transfer, ptr holds.
- **Write port:**
  - On a transfer edge: write_addr <= granted addr, write_data <= granted data, RegWrite <= 1.
  - Otherwise RegWrite <= 0, and write_addr/write_data hold their last value.
  - Address 0 is accepted and granted, but RegWrite stays 0 for it (r0 is hardwired zero).
- **Scoreboard:**
  - On an edge with rsv_valid=1 and rsv_addr!=0: busy[rsv_addr] <= 1.
  - On an edge with RegWrite=1: busy[write_addr] <= 0. This is the same edge on which the register file commits the write.
  - Same edge, same address for set and clear: set wins, because a new reservation supersedes the old one.
  - Different addresses on the same edge: both updates apply.
  - busy[0] is constantly 0.
  - Reserving a register that is already busy leaves it busy. No error is flagged.

## Timing
- **Reset** (rst=1 sampled at an edge):
  - ptr=0, RegWrite=0, write_addr=0, write_data=0, busy=all 0.
  - gnt is forced to 0 while rst=1. rst overrides any concurrent request or reservation.
- **Latency:**
  - Accept at edge N. RegWrite=1 during cycle N→N+1. Register file commits at edge N+1.
  - busy clears at edge N+1, so a read of the register in cycle N+1→N+2 returns the new value.
- **Throughput:** one write per cycle. Back-to-back transfers give RegWrite=1 continuously.
- **Fairness:** under continuous requests from all three sources, grants rotate 0,1,2,0,… Any requesting source is granted within 3 cycles.
- **Reset mid-operation:**
  - A write already registered (RegWrite=1) when rst is sampled is dropped: RegWrite=0 after the edge.
  - An un-granted request stays pending and competes again after rst deasserts, starting from ptr=0.

## Test plan
- **Reset:** assert rst with req=3'b111 and rsv_valid=1 -> gnt=0 throughout; after the edge RegWrite=0, busy=0, write_addr=0, write_data=0.
- **Single source:** source 1 requests addr 4, data 16'h0006 -> gnt=3'b010 same cycle; RegWrite=1, write_addr=4, write_data=6 next cycle; register 4 reads 6 after the following edge.
- **Round-robin:** all three requesters hold req for 6 cycles with distinct addrs 1/2/3 -> grant sequence 0,1,2,0,1,2; ptr returns to 0; RegWrite high for 6 consecutive cycles.
- **Scoreboard:**
  - Reserve addr 8, then source 2 writes addr 8, data 14 -> busy[8]=1 until the edge after RegWrite asserts, then 0.
  - Reserve addr 8 on the same edge as the clearing write -> busy[8] stays 1.
- **r0 handling:** source 0 writes addr 0, data 16'hFFFF -> gnt[0]=1, RegWrite stays 0; reserve addr 0 -> busy[0] stays 0.
- **Reset mid-flight:** grant source 0 at edge N, assert rst at edge N+1 -> RegWrite=0 after that edge and the target register is unchanged; source 1 holding req through reset is granted in the first cycle after rst deasserts.
